instr_fetch_stage: RTL

Instruction fetch stage sitting directly downstream of the program counter and upstream of decode. Takes the current PC address, issues a request/grant/response read to instruction memory, and registers the returned word plus its PC into the IF/ID output register with a valid/ready handshake. Produces the one-cycle `pc_advance` pulse that lets the PC step. Honours `flush` from the PC's branch/jump signalling by discarding in-flight and buffered instructions.

---
 rtl/instr_fetch_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid read, skid-buffered IF/ID register, flush drain.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
`timescale 1ns/1ps
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000240,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] pc_addr,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_busy,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        load;
  logic        out_free;
  logic [31:0] load_word;

  // Decode handshake: a word moves out when id_valid && id_ready in the same cycle;
  // the IF/ID register may be refilled in that same cycle.
  assign out_free  = !valid_q || id_ready;
  assign load_word = (state_q == S_HOLD) ? skid_q : imem_rdata;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    skid_d  = skid_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        addr_d  = pc_addr;
      end
      S_REQ: begin
        if (flush)         state_d = imem_gnt ? S_DRAIN : S_IDLE;
        else if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (out_free) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (id_ready) begin
          load    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // The killed response must still be consumed before a new request goes out.
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_word;
      pc_d    = addr_q;
    end else if (valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      skid_q  <= 32'h0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_advance = load;
  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = addr_q;
  assign id_valid   = valid_q;
  assign id_instr   = instr_q;
  assign id_pc      = pc_q;
  assign fetch_busy = (state_q != S_IDLE);
  assign dbg_state  = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (load)                          fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q != S_IDLE) && !load)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
